// File: rtl/lutram_read_checker_pkg.sv
// lutram_read_checker_pkg: shared FSM encoding, pattern modes and expected-bit helper
package lutram_read_checker_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CHECK = 2'd1, ST_DONE = 2'd2} state_t;
    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_ADDR0  = 2'd1;
    localparam logic [1:0] MODE_NADDR0 = 2'd2;
    localparam logic [1:0] MODE_ONE    = 2'd3;
    function automatic logic exp_bit(input logic [1:0] mode, input logic a0);
        return (mode == MODE_ZERO) ? 1'b0 : (mode == MODE_ADDR0) ? a0 : (mode == MODE_NADDR0) ? ~a0 : 1'b1;
    endfunction
endpackage

// File: rtl/lutram_err_counter.sv
// lutram_err_counter: saturating mismatch counter with synchronous clear
// Ports: clk, rst (async, active-high), clr (sync clear, wins over inc), inc (count one), cnt (current value)
module lutram_err_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/lutram_read_checker.sv
// lutram_read_checker: checks a full-depth LUTRAM read sweep against a fixed bit pattern
// Ports: clk_i, rst_i (async, active-high); start_i/mode_i begin a pass; valid_i/addr_i/spo_i/dpo_i carry read samples;
//        busy_o/done_o/pass_o report progress; spo/dpo error counts, first failing address and sequence error report detail
module lutram_read_checker
    import lutram_read_checker_pkg::*;
#(
    parameter int A_WIDTH   = 7,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic                 valid_i,
    input  logic [A_WIDTH-1:0]   addr_i,
    input  logic                 spo_i,
    input  logic                 dpo_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CNT_WIDTH-1:0] spo_err_cnt_o,
    output logic [CNT_WIDTH-1:0] dpo_err_cnt_o,
    output logic [A_WIDTH-1:0]   first_fail_addr_o,
    output logic                 first_fail_vld_o,
    output logic                 seq_err_o
);
    localparam logic [A_WIDTH-1:0] LAST = '1;
    state_t state, state_nxt;
    logic [1:0] mode_q;
    logic [A_WIDTH-1:0] exp_addr;
    logic sample, exp_d, spo_miss, dpo_miss;
    // a start in the same cycle as a sample restarts the pass and drops that sample
    assign sample   = state == ST_CHECK && valid_i && !start_i;
    assign exp_d    = exp_bit(mode_q, addr_i[0]);
    assign spo_miss = spo_i != exp_d;
    assign dpo_miss = dpo_i != exp_d;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= ST_IDLE;
        else state <= state_nxt;
    always_comb
        state_nxt = start_i ? ST_CHECK :
                    (sample && exp_addr == LAST) ? ST_DONE : state;
    always_comb begin
        busy_o = state == ST_CHECK;
        done_o = state == ST_DONE;
        pass_o = done_o && spo_err_cnt_o == '0 && dpo_err_cnt_o == '0 && !seq_err_o;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            mode_q            <= '0;
            exp_addr          <= '0;
            seq_err_o         <= 1'b0;
            first_fail_vld_o  <= 1'b0;
            first_fail_addr_o <= '0;
        end else if (start_i) begin
            mode_q            <= mode_i;
            exp_addr          <= '0;
            seq_err_o         <= 1'b0;
            first_fail_vld_o  <= 1'b0;
            first_fail_addr_o <= '0;
        end else if (sample) begin
            exp_addr <= exp_addr + 1'b1;
            if (addr_i != exp_addr) seq_err_o <= 1'b1;
            if ((spo_miss || dpo_miss) && !first_fail_vld_o) begin
                first_fail_vld_o  <= 1'b1;
                first_fail_addr_o <= addr_i;
            end
        end
    lutram_err_counter #(.W(CNT_WIDTH)) u_spo_cnt (
        .clk(clk_i), .rst(rst_i), .clr(start_i), .inc(sample && spo_miss), .cnt(spo_err_cnt_o)
    );
    lutram_err_counter #(.W(CNT_WIDTH)) u_dpo_cnt (
        .clk(clk_i), .rst(rst_i), .clr(start_i), .inc(sample && dpo_miss), .cnt(dpo_err_cnt_o)
    );
endmodule

// File: tb/tb_lutram_read_checker.sv
// tb_lutram_read_checker: directed self-checking bench for lutram_read_checker (8-bit and 4-bit counter builds)
module tb_lutram_read_checker;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, spo = 1'b0, dpo = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [6:0] addr = '0;
    logic busy, done, pass, ff_vld, seq_err;
    logic [7:0] spo_cnt, dpo_cnt;
    logic [6:0] ff_addr;
    logic busy4, done4, pass4, ff_vld4, seq_err4;
    logic [3:0] spo_cnt4, dpo_cnt4;
    logic [6:0] ff_addr4;
    int n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    lutram_read_checker #(.A_WIDTH(7), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .valid_i(valid), .addr_i(addr),
        .spo_i(spo), .dpo_i(dpo), .busy_o(busy), .done_o(done), .pass_o(pass),
        .spo_err_cnt_o(spo_cnt), .dpo_err_cnt_o(dpo_cnt), .first_fail_addr_o(ff_addr),
        .first_fail_vld_o(ff_vld), .seq_err_o(seq_err)
    );
    lutram_read_checker #(.A_WIDTH(7), .CNT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .valid_i(valid), .addr_i(addr),
        .spo_i(spo), .dpo_i(dpo), .busy_o(busy4), .done_o(done4), .pass_o(pass4),
        .spo_err_cnt_o(spo_cnt4), .dpo_err_cnt_o(dpo_cnt4), .first_fail_addr_o(ff_addr4),
        .first_fail_vld_o(ff_vld4), .seq_err_o(seq_err4)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    task automatic start_pass(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic send(input int a, input logic s, input logic d);
        addr  = a[6:0];
        spo   = s;
        dpo   = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_spo_cnt"}, spo_cnt, 0);
        check({tag, "_dpo_cnt"}, dpo_cnt, 0);
        check({tag, "_ff_vld"}, ff_vld, 0);
        check({tag, "_ff_addr"}, ff_addr, 0);
        check({tag, "_seq_err"}, seq_err, 0);
    endtask
    initial begin
        logic b;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        send(0, 1'b1, 1'b1);
        check_idle("idle_ignore");
        // mode 1 clean sweep
        start_pass(2'd1);
        check("m1_busy", busy, 1);
        check("m1_done_early", done, 0);
        for (int i = 0; i < 128; i++) begin
            if (i == 127) check("m1_done_before_last", done, 0);
            b = i[0];
            send(i, b, b);
        end
        check("m1_done", done, 1);
        check("m1_busy_end", busy, 0);
        check("m1_pass", pass, 1);
        check("m1_spo_cnt", spo_cnt, 0);
        check("m1_dpo_cnt", dpo_cnt, 0);
        check("m1_ff_vld", ff_vld, 0);
        send(3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("m1_done_hold", done, 1);
        check("m1_pass_hold", pass, 1);
        check("m1_done_ignore", dpo_cnt, 0);
        // mode 0, spo errors at 5 and 9
        start_pass(2'd0);
        check("m0_done_cleared", done, 0);
        check("m0_pass_cleared", pass, 0);
        for (int i = 0; i < 128; i++) begin
            send(i, (i == 5 || i == 9), 1'b0);
            if (i == 5) begin
                check("m0_ff_vld_mid", ff_vld, 1);
                check("m0_ff_addr_mid", ff_addr, 5);
            end
        end
        check("m0_done", done, 1);
        check("m0_spo_cnt", spo_cnt, 2);
        check("m0_dpo_cnt", dpo_cnt, 0);
        check("m0_ff_addr", ff_addr, 5);
        check("m0_ff_vld", ff_vld, 1);
        check("m0_pass", pass, 0);
        // mode 3, dpo always wrong: 128 on 8-bit counter, saturated 15 on 4-bit
        start_pass(2'd3);
        for (int i = 0; i < 128; i++) send(i, 1'b1, 1'b0);
        check("m3_done", done, 1);
        check("m3_dpo_cnt8", dpo_cnt, 128);
        check("m3_dpo_cnt4", dpo_cnt4, 15);
        check("m3_spo_cnt8", spo_cnt, 0);
        check("m3_ff_addr", ff_addr, 0);
        check("m3_pass4", pass4, 0);
        // mode 2 clean sweep
        start_pass(2'd2);
        check("m2_cnt_cleared", dpo_cnt, 0);
        for (int i = 0; i < 128; i++) begin
            b = ~i[0];
            send(i, b, b);
        end
        check("m2_pass", pass, 1);
        check("m2_pass4", pass4, 1);
        // mode 1, address 10 skipped: order error, data still correct
        start_pass(2'd1);
        for (int i = 0; i < 128; i++) begin
            int a;
            a = (i < 10) ? i : i + 1;
            b = a[0];
            send(a, b, b);
            if (i == 9) check("seq_no_err_yet", seq_err, 0);
        end
        check("seq_done", done, 1);
        check("seq_err", seq_err, 1);
        check("seq_spo_cnt", spo_cnt, 0);
        check("seq_dpo_cnt", dpo_cnt, 0);
        check("seq_pass", pass, 0);
        // reset mid-pass after 60 samples
        start_pass(2'd1);
        for (int i = 0; i < 60; i++) begin
            b = i[0];
            send(i, b, (i == 3) ? ~b : b);
        end
        check("rst_pre_dpo_cnt", dpo_cnt, 1);
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 60; i < 70; i++) send(i, 1'b0, 1'b0);
        check_idle("rst_abandon");
        start_pass(2'd1);
        for (int i = 0; i < 128; i++) begin
            b = i[0];
            send(i, b, b);
        end
        check("rst_after_pass", pass, 1);
        // restart at sample 30 of a failing pass
        start_pass(2'd0);
        for (int i = 0; i < 30; i++) send(i, 1'b1, 1'b0);
        check("rs_spo_cnt_pre", spo_cnt, 30);
        check("rs_ff_vld_pre", ff_vld, 1);
        start_pass(2'd0);
        check("rs_spo_cnt", spo_cnt, 0);
        check("rs_ff_vld", ff_vld, 0);
        check("rs_busy", busy, 1);
        for (int i = 0; i < 128; i++) send(i, 1'b0, 1'b0);
        check("rs_done", done, 1);
        check("rs_pass", pass, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lutram_read_checker.md
LUTRAM_READ_CHECKER -- requirements
Module: lutram_read_checker

Interface
REQ-001 Parameter A_WIDTH, default 7, address width of the LUTRAM under test; DEPTH = 2**A_WIDTH entries.
REQ-002 Parameter CNT_WIDTH, default 8, width of each error counter.
REQ-003 clk_i  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  single-cycle pulse that begins one check pass.
REQ-006 mode_i  input  2  expected-pattern select, sampled at start: 0 all-zero, 1 addr[0], 2 ~addr[0], 3 all-one.
REQ-007 valid_i  input  1  read sample valid this cycle.
REQ-008 addr_i  input  A_WIDTH  address of the read sample.
REQ-009 spo_i  input  1  single-port read data sample.
REQ-010 dpo_i  input  1  dual-port read data sample.
REQ-011 busy_o  output  1  high while in CHECK.
REQ-012 done_o  output  1  high in DONE; held until the next start or reset.
REQ-013 pass_o  output  1  valid when done_o is high: no data mismatch and no sequence error.
REQ-014 spo_err_cnt_o  output  CNT_WIDTH  SPO mismatch count.
REQ-015 dpo_err_cnt_o  output  CNT_WIDTH  DPO mismatch count.
REQ-016 first_fail_addr_o  output  A_WIDTH  address of the first mismatching sample.
REQ-017 first_fail_vld_o  output  1  first_fail_addr_o holds a captured address.
REQ-018 seq_err_o  output  1  a sample arrived out of address order.

Function
REQ-019 FSM states IDLE, CHECK, DONE; IDLE->CHECK on start_i; CHECK->DONE on the accepted sample at expected address DEPTH-1; DONE->CHECK on start_i.
REQ-020 On start_i: latch mode_i, clear the expected-address counter, both error counters, first_fail_vld_o and seq_err_o, and deassert done_o; busy_o is high from the next cycle.
REQ-021 start_i while in CHECK restarts the pass with the same clearing as REQ-020.
REQ-022 In CHECK, each valid_i cycle compares spo_i and dpo_i against expected = f(mode, addr_i).
REQ-023 Each valid_i cycle advances the expected-address counter, which wraps at DEPTH-1.
REQ-024 valid_i is ignored in IDLE and DONE.
REQ-025 addr_i != expected address in CHECK sets seq_err_o (sticky); the data comparison still uses addr_i.
REQ-026 Each error counter increments by 1 per mismatching sample and saturates at all-ones.
REQ-027 The first mismatch on either port captures addr_i and sets first_fail_vld_o; later mismatches do not overwrite it.
REQ-028 Result registers update one cycle after the sample, so done_o rises the cycle after the last sample is accepted.
REQ-029 pass_o = done_o AND both counters zero AND NOT seq_err_o; pass_o is 0 outside DONE.

Reset
REQ-030 While rst_i is high: state is IDLE; busy_o, done_o, pass_o, seq_err_o and first_fail_vld_o are 0; counters are 0; first_fail_addr_o is 0; latched mode is 0.
REQ-031 Reset mid-pass abandons the pass with no DONE; a new start_i is required.

Structure
REQ-032 A shared package holds the FSM state encoding, the four mode constants and the expected-bit function.
REQ-033 One sub-module, lutram_err_counter (saturating counter with synchronous clear), is instantiated once per port.

Verification
REQ-034 mode 1, 128 samples at addr 0..127 with spo = dpo = addr[0] -> done_o the cycle after addr 127, pass_o = 1, counters = 0.
REQ-035 mode 0, spo forced 1 at addr 5 and 9 -> spo_err_cnt_o = 2, dpo_err_cnt_o = 0, first_fail_addr_o = 5, pass_o = 0.
REQ-036 mode 3, dpo = 0 on all 128 samples with CNT_WIDTH = 8 -> dpo_err_cnt_o = 128; with CNT_WIDTH = 4 -> saturates at 15.
REQ-037 mode 1, addresses 0..9 then 11 with correct data -> seq_err_o = 1, pass_o = 0 at done.
REQ-038 rst_i asserted at sample 60 -> all outputs 0 immediately; a later start_i followed by a clean pass -> pass_o = 1.
REQ-039 start_i at sample 30 of a failing pass -> counters and flags clear, and the following clean 128-sample pass gives pass_o = 1.
